// File: rtl/entry_sequencer_pkg.sv
// Shared types and constants for the operand-entry sequencer.
package entry_seq_pkg;

   typedef enum logic [2:0] {
      S_A    = 3'd0,
      S_B    = 3'd1,
      S_EXEC = 3'd2,
      S_WAIT = 3'd3,
      S_SHOW = 3'd4
   } state_t;

   localparam logic [1:0] PHASE_A    = 2'd0;
   localparam logic [1:0] PHASE_B    = 2'd1;
   localparam logic [1:0] PHASE_BUSY = 2'd2;
   localparam logic [1:0] PHASE_SHOW = 2'd3;

   localparam int DEF_DEBOUNCE_CYCLES = 16;
   localparam int DEF_OP_TIMEOUT      = 64;
   localparam int SYNC_STAGES         = 2;

   // Display phase reported for a given controller state.
   function automatic logic [1:0] phase_of(input state_t s);
      logic [1:0] p;
      p = PHASE_A;
      case (s)
         S_A:           p = PHASE_A;
         S_B:           p = PHASE_B;
         S_EXEC,
         S_WAIT:        p = PHASE_BUSY;
         S_SHOW:        p = PHASE_SHOW;
         default:       p = PHASE_A;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/entry_sequencer_if.sv
// Handshake bundle between the entry sequencer and its surroundings
// (pushbutton, datapath, display mux).
interface entry_sequencer_if;
   logic       enter;
   logic       op_done;
   logic       load_a;
   logic       load_b;
   logic       start_op;
   logic       show_result;
   logic [1:0] phase;
   logic       timeout_err;

   // The sequencer itself.
   modport master (
      input  enter, op_done,
      output load_a, load_b, start_op, show_result, phase, timeout_err
   );

   // Button / datapath / display side.
   modport slave (
      output enter, op_done,
      input  load_a, load_b, start_op, show_result, phase, timeout_err
   );
endinterface

// File: rtl/entry_sequencer_debouncer.sv
// Pushbutton conditioning: synchronizer, stability filter, rising-edge press pulse.
module button_debouncer
   import entry_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic level,
   output logic press
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic [CW-1:0]          cnt_reg;
   logic                   filt_reg;
   logic                   filt_d_reg;
   logic                   press_reg;
   logic                   synced;

   // Synchronizer chain; each stage samples the one before it.
   generate
      for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
         always_ff @(posedge clk) begin
            if (reset)
               sync_reg[gi] <= 1'b0;
            else if (gi == 0)
               sync_reg[gi] <= level;
            else
               sync_reg[gi] <= sync_reg[(gi == 0) ? 0 : gi - 1];
         end
      end
   endgenerate

   assign synced = sync_reg[SYNC_STAGES-1];

   // Filter: the accepted level flips only after a run of differing samples.
   // It resets high so a button held through reset must be released first.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_reg    <= '0;
         filt_reg   <= 1'b1;
         filt_d_reg <= 1'b1;
         press_reg  <= 1'b0;
      end else begin
         filt_d_reg <= filt_reg;
         press_reg  <= filt_reg & ~filt_d_reg;
         if (synced == filt_reg) begin
            cnt_reg <= '0;
         end else if (cnt_reg == CNT_LAST) begin
            filt_reg <= synced;
            cnt_reg  <= '0;
         end else begin
            cnt_reg <= cnt_reg + CW'(1);
         end
      end
   end

   assign press = press_reg;

endmodule

// File: rtl/entry_sequencer.sv
// Operand-entry controller: A, B, launch, wait with timeout, show result.
module entry_sequencer
   import entry_seq_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int OP_TIMEOUT      = DEF_OP_TIMEOUT
) (
   input  logic               clk,
   input  logic               reset,
   entry_sequencer_if.master  bus
);

   localparam int WW = $clog2(OP_TIMEOUT + 1);
   localparam logic [WW-1:0] WAIT_LAST = WW'(OP_TIMEOUT - 1);

   logic          press;
   state_t        state_reg,    state_next;
   logic [WW-1:0] wait_cnt_reg, wait_cnt_next;
   logic          load_a_reg,   load_a_next;
   logic          load_b_reg,   load_b_next;
   logic          start_op_reg, start_op_next;
   logic          show_reg,     show_next;
   logic [1:0]    phase_reg,    phase_next;
   logic          err_reg,      err_next;

   button_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk   (clk),
      .reset (reset),
      .level (bus.enter),
      .press (press)
   );

   // State, wait counter and all outputs are registered together.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= S_A;
         wait_cnt_reg <= '0;
         load_a_reg   <= 1'b0;
         load_b_reg   <= 1'b0;
         start_op_reg <= 1'b0;
         show_reg     <= 1'b0;
         phase_reg    <= PHASE_A;
         err_reg      <= 1'b0;
      end else begin
         state_reg    <= state_next;
         wait_cnt_reg <= wait_cnt_next;
         load_a_reg   <= load_a_next;
         load_b_reg   <= load_b_next;
         start_op_reg <= start_op_next;
         show_reg     <= show_next;
         phase_reg    <= phase_next;
         err_reg      <= err_next;
      end
   end

   // Next state and next outputs; presses outside S_A/S_B/S_SHOW are dropped.
   always_comb begin
      state_next    = state_reg;
      wait_cnt_next = wait_cnt_reg;
      load_a_next   = 1'b0;
      load_b_next   = 1'b0;
      start_op_next = 1'b0;
      err_next      = err_reg;
      case (state_reg)
         S_A: begin
            if (press) begin
               state_next  = S_B;
               load_a_next = 1'b1;
               err_next    = 1'b0;
            end
         end
         S_B: begin
            if (press) begin
               state_next  = S_EXEC;
               load_b_next = 1'b1;
            end
         end
         S_EXEC: begin
            state_next    = S_WAIT;
            start_op_next = 1'b1;
            wait_cnt_next = '0;
         end
         S_WAIT: begin
            // op_done takes priority over an expiry in the same cycle.
            if (bus.op_done) begin
               state_next    = S_SHOW;
               wait_cnt_next = '0;
            end else if (wait_cnt_reg == WAIT_LAST) begin
               state_next    = S_A;
               err_next      = 1'b1;
               wait_cnt_next = '0;
            end else begin
               wait_cnt_next = wait_cnt_reg + WW'(1);
            end
         end
         S_SHOW: begin
            if (press) state_next = S_A;
         end
         default: state_next = S_A;
      endcase
      show_next  = (state_next == S_SHOW);
      phase_next = phase_of(state_next);
   end

   assign bus.load_a      = load_a_reg;
   assign bus.load_b      = load_b_reg;
   assign bus.start_op    = start_op_reg;
   assign bus.show_result = show_reg;
   assign bus.phase       = phase_reg;
   assign bus.timeout_err = err_reg;

endmodule

// File: tb/tb_entry_sequencer.sv
// Directed bench for entry_sequencer with DEBOUNCE_CYCLES=4, OP_TIMEOUT=8.
// A clean press raised just after an edge yields its strobe 8 edges later.
module tb_entry_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   na;
   int   nb;
   int   ns;
   int   multi;

   entry_sequencer_if bus ();

   entry_sequencer #(
      .DEBOUNCE_CYCLES (4),
      .OP_TIMEOUT      (8)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Strobe monitor: counts each strobe cycle and any overlapping strobes.
   initial begin
      na = 0; nb = 0; ns = 0; multi = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            na += int'(bus.load_a);
            nb += int'(bus.load_b);
            ns += int'(bus.start_op);
            if ((int'(bus.load_a) + int'(bus.load_b) + int'(bus.start_op)) > 1) multi++;
         end
      end
   end

   task automatic cyc(input int n);
      for (int i = 0; i < n; i++) @(posedge clk);
      #1;
   endtask

   task automatic press_hold();
      bus.enter = 1'b1;
      cyc(8);
   endtask

   task automatic release_btn();
      bus.enter = 1'b0;
      cyc(8);
   endtask

   task automatic test_reset();
      reset = 1'b1; bus.enter = 1'b0; bus.op_done = 1'b0;
      cyc(3);
      reset = 1'b0;
      checks++;
      if ({bus.load_a, bus.load_b, bus.start_op, bus.show_result, bus.timeout_err} !== 5'b0) begin
         errors++; $display("FAIL reset_outs got %b want 00000",
            {bus.load_a, bus.load_b, bus.start_op, bus.show_result, bus.timeout_err});
      end
      checks++;
      if (bus.phase !== 2'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", bus.phase); end
      cyc(8);
      $display("test_reset done");
   endtask

   task automatic test_full_flow();
      int ba, bb, bs;
      ba = na; bb = nb; bs = ns;
      bus.enter = 1'b1;
      cyc(7);
      checks++;
      if (bus.load_a !== 1'b0) begin errors++; $display("FAIL flow_early_load_a got %b want 0", bus.load_a); end
      cyc(1);
      checks++;
      if (bus.load_a !== 1'b1 || bus.phase !== 2'd1) begin
         errors++; $display("FAIL flow_load_a got load_a=%b phase=%0d want 1/1", bus.load_a, bus.phase);
      end
      cyc(1);
      checks++;
      if (bus.load_a !== 1'b0) begin errors++; $display("FAIL flow_load_a_width got %b want 0", bus.load_a); end
      release_btn();
      press_hold();
      checks++;
      if (bus.load_b !== 1'b1 || bus.phase !== 2'd2) begin
         errors++; $display("FAIL flow_load_b got load_b=%b phase=%0d want 1/2", bus.load_b, bus.phase);
      end
      cyc(1);
      checks++;
      if (bus.start_op !== 1'b1 || bus.phase !== 2'd2) begin
         errors++; $display("FAIL flow_start got start_op=%b phase=%0d want 1/2", bus.start_op, bus.phase);
      end
      cyc(1);
      bus.op_done = 1'b1;
      cyc(1);
      bus.op_done = 1'b0;
      checks++;
      if (bus.show_result !== 1'b1 || bus.phase !== 2'd3) begin
         errors++; $display("FAIL flow_show got show=%b phase=%0d want 1/3", bus.show_result, bus.phase);
      end
      release_btn();
      press_hold();
      checks++;
      if (bus.show_result !== 1'b0 || bus.phase !== 2'd0) begin
         errors++; $display("FAIL flow_exit got show=%b phase=%0d want 0/0", bus.show_result, bus.phase);
      end
      checks++;
      if (na - ba != 1 || nb - bb != 1 || ns - bs != 1) begin
         errors++; $display("FAIL flow_counts got a=%0d b=%0d s=%0d want 1/1/1", na - ba, nb - bb, ns - bs);
      end
      release_btn();
      $display("test_full_flow done");
   endtask

   task automatic test_bounce();
      int ba;
      ba = na;
      for (int i = 0; i < 3; i++) begin
         bus.enter = 1'b1; cyc(2);
         bus.enter = 1'b0; cyc(2);
      end
      bus.enter = 1'b1;
      cyc(7);
      checks++;
      if (na != ba || bus.load_a !== 1'b0) begin
         errors++; $display("FAIL bounce_early got count=%0d load_a=%b want 0/0", na - ba, bus.load_a);
      end
      cyc(1);
      checks++;
      if (bus.load_a !== 1'b1) begin errors++; $display("FAIL bounce_load_a got %b want 1", bus.load_a); end
      release_btn();
      checks++;
      if (na - ba != 1) begin errors++; $display("FAIL bounce_count got %0d want 1", na - ba); end
      $display("test_bounce done");
   endtask

   task automatic test_timeout();
      press_hold();
      checks++;
      if (bus.load_b !== 1'b1) begin errors++; $display("FAIL to_load_b got %b want 1", bus.load_b); end
      bus.enter = 1'b0;
      cyc(8);
      checks++;
      if (bus.phase !== 2'd2 || bus.timeout_err !== 1'b0) begin
         errors++; $display("FAIL to_early got phase=%0d err=%b want 2/0", bus.phase, bus.timeout_err);
      end
      cyc(1);
      checks++;
      if (bus.phase !== 2'd0 || bus.timeout_err !== 1'b1) begin
         errors++; $display("FAIL to_expire got phase=%0d err=%b want 0/1", bus.phase, bus.timeout_err);
      end
      press_hold();
      checks++;
      if (bus.load_a !== 1'b1 || bus.timeout_err !== 1'b0 || bus.phase !== 2'd1) begin
         errors++; $display("FAIL to_clear got load_a=%b err=%b phase=%0d want 1/0/1",
            bus.load_a, bus.timeout_err, bus.phase);
      end
      release_btn();
      $display("test_timeout done");
   endtask

   task automatic test_race();
      press_hold();
      bus.enter = 1'b0;
      cyc(8);
      bus.op_done = 1'b1;
      cyc(1);
      bus.op_done = 1'b0;
      checks++;
      if (bus.phase !== 2'd3 || bus.show_result !== 1'b1 || bus.timeout_err !== 1'b0) begin
         errors++; $display("FAIL race got phase=%0d show=%b err=%b want 3/1/0",
            bus.phase, bus.show_result, bus.timeout_err);
      end
      press_hold();
      checks++;
      if (bus.phase !== 2'd0) begin errors++; $display("FAIL race_exit got phase=%0d want 0", bus.phase); end
      release_btn();
      $display("test_race done");
   endtask

   task automatic test_busy();
      int ba;
      press_hold();
      release_btn();
      ba = na;
      // Short press for B so the filter is low again while still busy.
      bus.enter = 1'b1; cyc(4);
      bus.enter = 1'b0; cyc(4);
      checks++;
      if (bus.load_b !== 1'b1) begin errors++; $display("FAIL busy_load_b got %b want 1", bus.load_b); end
      bus.enter = 1'b1;
      cyc(8);
      checks++;
      if (bus.phase !== 2'd2 || bus.load_a !== 1'b0) begin
         errors++; $display("FAIL busy_drop got phase=%0d load_a=%b want 2/0", bus.phase, bus.load_a);
      end
      bus.op_done = 1'b1;
      cyc(1);
      bus.op_done = 1'b0;
      cyc(3);
      checks++;
      if (bus.phase !== 2'd3 || na != ba) begin
         errors++; $display("FAIL busy_not_queued got phase=%0d load_a_count=%0d want 3/0", bus.phase, na - ba);
      end
      release_btn();
      press_hold();
      release_btn();
      $display("test_busy done");
   endtask

   task automatic test_reset_in_wait();
      int ba;
      press_hold();
      release_btn();
      press_hold();
      cyc(2);
      checks++;
      if (bus.phase !== 2'd2) begin errors++; $display("FAIL rst_pre got phase=%0d want 2", bus.phase); end
      reset = 1'b1;
      cyc(1);
      reset = 1'b0;
      checks++;
      if ({bus.load_a, bus.load_b, bus.start_op, bus.show_result, bus.timeout_err, bus.phase} !== 7'b0) begin
         errors++; $display("FAIL rst_wait_outs got %b want 0000000",
            {bus.load_a, bus.load_b, bus.start_op, bus.show_result, bus.timeout_err, bus.phase});
      end
      ba = na;
      cyc(12);
      checks++;
      if (na != ba || bus.phase !== 2'd0) begin
         errors++; $display("FAIL rst_held got load_a_count=%0d phase=%0d want 0/0", na - ba, bus.phase);
      end
      release_btn();
      press_hold();
      checks++;
      if (bus.load_a !== 1'b1) begin errors++; $display("FAIL rst_repress got %b want 1", bus.load_a); end
      release_btn();
      checks++;
      if (multi != 0) begin errors++; $display("FAIL strobe_overlap got %0d want 0", multi); end
      $display("test_reset_in_wait done");
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset = 1'b1;
      bus.enter = 1'b0;
      bus.op_done = 1'b0;
      test_reset();
      test_full_flow();
      test_bounce();
      test_timeout();
      test_race();
      test_busy();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
